unidade_controle: RTL and testbench

- Moore FSM that sequences the ultimate tic-tac-toe datapath (fluxo_dados) for one game.
- Covers four stages:
  - Macro-cell selection: manual selection, or automatic selection from the previous micro.
  - Micro move validation.
  - Board and board-state RAM writes, with a timer wait.
  - Win check and player swap.
- Drives every control input of fluxo_dados and consumes its status outputs.

---
 rtl/unidade_controle_if.sv | 54 +++++
 rtl/unidade_controle.sv | 192 +++++++++++++++++++
 tb/tb_unidade_controle.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/unidade_controle_if.sv
// unidade_controle_if
//   Control/status bundle between the game sequencer (unidade_controle) and
//   the ultimate tic-tac-toe datapath (fluxo_dados).
//
//   Requests/status (into the sequencer):
//     iniciar, tem_jogada, macro_vencida, micro_jogada, fim_jogo, fimT
//   Controls (out of the sequencer):
//     zeraEdge, zeraR_micro, zeraR_macro, zeraFlipFlopT, zeraRAM, zeraT,
//     registraR_micro, registraR_macro, sinal_macro, sinal_valida_macro,
//     troca_jogador, we_board, we_board_state, contaT, pronto, db_estado[4:0]
//
//   master : sequencer side (drives controls, reads status)
//   slave  : datapath/stimulus side (drives status, reads controls)
interface unidade_controle_if;

   logic       iniciar;
   logic       tem_jogada;
   logic       macro_vencida;
   logic       micro_jogada;
   logic       fim_jogo;
   logic       fimT;

   logic       zeraEdge;
   logic       zeraR_micro;
   logic       zeraR_macro;
   logic       zeraFlipFlopT;
   logic       zeraRAM;
   logic       zeraT;
   logic       registraR_micro;
   logic       registraR_macro;
   logic       sinal_macro;
   logic       sinal_valida_macro;
   logic       troca_jogador;
   logic       we_board;
   logic       we_board_state;
   logic       contaT;
   logic       pronto;
   logic [4:0] db_estado;

   modport master (
      input  iniciar, tem_jogada, macro_vencida, micro_jogada, fim_jogo, fimT,
      output zeraEdge, zeraR_micro, zeraR_macro, zeraFlipFlopT, zeraRAM, zeraT,
             registraR_micro, registraR_macro, sinal_macro, sinal_valida_macro,
             troca_jogador, we_board, we_board_state, contaT, pronto, db_estado
   );

   modport slave (
      output iniciar, tem_jogada, macro_vencida, micro_jogada, fim_jogo, fimT,
      input  zeraEdge, zeraR_micro, zeraR_macro, zeraFlipFlopT, zeraRAM, zeraT,
             registraR_micro, registraR_macro, sinal_macro, sinal_valida_macro,
             troca_jogador, we_board, we_board_state, contaT, pronto, db_estado
   );

endinterface

// File: rtl/unidade_controle.sv
// unidade_controle
//   Moore sequencer for one game of ultimate tic-tac-toe. Walks the datapath
//   through macro selection (manual or inherited from the previous micro),
//   micro validation, board / board-state writes with a timer wait, win check
//   and player swap. Every output is a pure decode of the state register.
//
//   Ports:
//     clock : system clock, rising edge
//     reset : asynchronous, active-low; forces inicial immediately
//     bus   : unidade_controle_if.master (status in, controls out)
//
//   code | state            | meaning
//   -----+------------------+-----------------------------------------------
//    00  | inicial          | idle after reset, waits for iniciar
//    01  | preparacao       | clear edge det, registers, flip-flop, RAMs, timer
//    02  | espera_macro     | player picks any macro cell
//    03  | registra_macro   | load macro register from botoes
//    04  | valida_macro     | reject an already decided macro
//    05  | espera_micro     | player picks a micro cell
//    06  | registra_micro   | load micro register
//    07  | valida_micro     | reject an occupied micro
//    08  | escreve_board    | write the move to the board RAM
//    09  | espera_board     | let the timer run until fimT
//    0A  | escreve_state    | write the macro result to board-state RAM
//    0B  | verifica_fim     | game decided -> fim
//    0C  | troca            | swap players
//    0D  | verifica_proxima | is the macro named by the last micro decided?
//    0E  | proxima_livre    | yes: clear registers, next player picks freely
//    0F  | fim              | game over, waits for iniciar
//    10  | registra_auto    | no: macro register takes the previous micro
//    11  | limpa_micro      | clear micro register, go pick a micro
module unidade_controle (
   input  logic                  clock,
   input  logic                  reset,
   unidade_controle_if.master    bus
);

   typedef enum logic [4:0] {
      S_INICIAL          = 5'h00,
      S_PREPARACAO       = 5'h01,
      S_ESPERA_MACRO     = 5'h02,
      S_REGISTRA_MACRO   = 5'h03,
      S_VALIDA_MACRO     = 5'h04,
      S_ESPERA_MICRO     = 5'h05,
      S_REGISTRA_MICRO   = 5'h06,
      S_VALIDA_MICRO     = 5'h07,
      S_ESCREVE_BOARD    = 5'h08,
      S_ESPERA_BOARD     = 5'h09,
      S_ESCREVE_STATE    = 5'h0A,
      S_VERIFICA_FIM     = 5'h0B,
      S_TROCA            = 5'h0C,
      S_VERIFICA_PROXIMA = 5'h0D,
      S_PROXIMA_LIVRE    = 5'h0E,
      S_FIM              = 5'h0F,
      S_REGISTRA_AUTO    = 5'h10,
      S_LIMPA_MICRO      = 5'h11
   } estado_t;

   estado_t estado_q;
   estado_t estado_d;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_q <= S_INICIAL;
      end else begin
         estado_q <= estado_d;
      end
   end

   // Next state. tem_jogada is only looked at in the two wait states and
   // iniciar only in inicial/fim, so stray pulses elsewhere fall through.
   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         S_INICIAL:          if (bus.iniciar) estado_d = S_PREPARACAO;
         S_PREPARACAO:       estado_d = S_ESPERA_MACRO;
         S_ESPERA_MACRO:     if (bus.tem_jogada) estado_d = S_REGISTRA_MACRO;
         S_REGISTRA_MACRO:   estado_d = S_VALIDA_MACRO;
         S_VALIDA_MACRO:     estado_d = bus.macro_vencida ? S_ESPERA_MACRO
                                                          : S_ESPERA_MICRO;
         S_ESPERA_MICRO:     if (bus.tem_jogada) estado_d = S_REGISTRA_MICRO;
         S_REGISTRA_MICRO:   estado_d = S_VALIDA_MICRO;
         S_VALIDA_MICRO:     estado_d = bus.micro_jogada ? S_ESPERA_MICRO
                                                         : S_ESCREVE_BOARD;
         S_ESCREVE_BOARD:    estado_d = S_ESPERA_BOARD;
         S_ESPERA_BOARD:     if (bus.fimT) estado_d = S_ESCREVE_STATE;
         S_ESCREVE_STATE:    estado_d = S_VERIFICA_FIM;
         S_VERIFICA_FIM:     estado_d = bus.fim_jogo ? S_FIM : S_TROCA;
         S_TROCA:            estado_d = S_VERIFICA_PROXIMA;
         // Here the board-state RAM is addressed by micro, so macro_vencida
         // tells whether the macro the opponent was sent to is still open.
         S_VERIFICA_PROXIMA: estado_d = bus.macro_vencida ? S_PROXIMA_LIVRE
                                                          : S_REGISTRA_AUTO;
         S_PROXIMA_LIVRE:    estado_d = S_ESPERA_MACRO;
         S_REGISTRA_AUTO:    estado_d = S_LIMPA_MICRO;
         S_LIMPA_MICRO:      estado_d = S_ESPERA_MICRO;
         S_FIM:              if (bus.iniciar) estado_d = S_PREPARACAO;
         default:            estado_d = S_INICIAL;
      endcase
   end

   // Output decode.
   always_comb begin
      bus.zeraEdge           = 1'b0;
      bus.zeraR_micro        = 1'b0;
      bus.zeraR_macro        = 1'b0;
      bus.zeraFlipFlopT      = 1'b0;
      bus.zeraRAM            = 1'b0;
      bus.zeraT              = 1'b0;
      bus.registraR_micro    = 1'b0;
      bus.registraR_macro    = 1'b0;
      bus.sinal_macro        = 1'b0;
      bus.sinal_valida_macro = 1'b0;
      bus.troca_jogador      = 1'b0;
      bus.we_board           = 1'b0;
      bus.we_board_state     = 1'b0;
      bus.contaT             = 1'b0;
      bus.pronto             = 1'b0;
      case (estado_q)
         S_PREPARACAO: begin
            bus.zeraEdge      = 1'b1;
            bus.zeraR_micro   = 1'b1;
            bus.zeraR_macro   = 1'b1;
            bus.zeraFlipFlopT = 1'b1;
            bus.zeraRAM       = 1'b1;
            bus.zeraT         = 1'b1;
         end
         S_ESPERA_MACRO: begin
            bus.sinal_macro        = 1'b1;
            bus.sinal_valida_macro = 1'b1;
            bus.zeraT              = 1'b1;
         end
         S_REGISTRA_MACRO: begin
            bus.sinal_macro        = 1'b1;
            bus.registraR_macro    = 1'b1;
            bus.sinal_valida_macro = 1'b1;
         end
         S_VALIDA_MACRO: begin
            bus.sinal_valida_macro = 1'b1;
         end
         S_ESPERA_MICRO: begin
            bus.sinal_valida_macro = 1'b1;
            bus.zeraT              = 1'b1;
         end
         S_REGISTRA_MICRO: begin
            bus.registraR_micro    = 1'b1;
            bus.sinal_valida_macro = 1'b1;
         end
         S_VALIDA_MICRO: begin
            bus.sinal_valida_macro = 1'b1;
         end
         S_ESCREVE_BOARD: begin
            bus.we_board           = 1'b1;
            bus.sinal_valida_macro = 1'b1;
         end
         S_ESPERA_BOARD: begin
            bus.contaT             = 1'b1;
            bus.sinal_valida_macro = 1'b1;
         end
         S_ESCREVE_STATE: begin
            bus.we_board_state     = 1'b1;
            bus.sinal_valida_macro = 1'b1;
            bus.zeraT              = 1'b1;
         end
         S_VERIFICA_FIM: begin
            bus.sinal_valida_macro = 1'b1;
         end
         S_TROCA: begin
            bus.troca_jogador = 1'b1;
         end
         S_PROXIMA_LIVRE: begin
            bus.zeraR_macro = 1'b1;
            bus.zeraR_micro = 1'b1;
         end
         // sinal_macro stays 0 so the macro register loads the micro value.
         S_REGISTRA_AUTO: begin
            bus.registraR_macro = 1'b1;
         end
         S_LIMPA_MICRO: begin
            bus.zeraR_micro        = 1'b1;
            bus.sinal_valida_macro = 1'b1;
         end
         S_FIM: begin
            bus.pronto = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle.sv
module tb_unidade_controle;

   logic clock;
   logic reset;
   int   vectors;
   int   miscompares;

   unidade_controle_if u_if ();

   unidade_controle dut (
      .clock (clock),
      .reset (reset),
      .bus   (u_if)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Expected output vectors, bit order:
   // [14]zeraEdge [13]zeraR_micro [12]zeraR_macro [11]zeraFlipFlopT
   // [10]zeraRAM [9]zeraT [8]registraR_micro [7]registraR_macro
   // [6]sinal_macro [5]sinal_valida_macro [4]troca_jogador [3]we_board
   // [2]we_board_state [1]contaT [0]pronto
   localparam logic [14:0] O_00 = 15'b000000000000000;
   localparam logic [14:0] O_01 = 15'b111111000000000;
   localparam logic [14:0] O_02 = 15'b000001001100000;
   localparam logic [14:0] O_03 = 15'b000000011100000;
   localparam logic [14:0] O_04 = 15'b000000000100000;
   localparam logic [14:0] O_05 = 15'b000001000100000;
   localparam logic [14:0] O_06 = 15'b000000100100000;
   localparam logic [14:0] O_07 = 15'b000000000100000;
   localparam logic [14:0] O_08 = 15'b000000000101000;
   localparam logic [14:0] O_09 = 15'b000000000100010;
   localparam logic [14:0] O_0A = 15'b000001000100100;
   localparam logic [14:0] O_0B = 15'b000000000100000;
   localparam logic [14:0] O_0C = 15'b000000000010000;
   localparam logic [14:0] O_0D = 15'b000000000000000;
   localparam logic [14:0] O_0E = 15'b011000000000000;
   localparam logic [14:0] O_0F = 15'b000000000000001;
   localparam logic [14:0] O_10 = 15'b000000010000000;
   localparam logic [14:0] O_11 = 15'b010000000100000;

   function automatic logic [14:0] outs();
      return {u_if.zeraEdge, u_if.zeraR_micro, u_if.zeraR_macro,
              u_if.zeraFlipFlopT, u_if.zeraRAM, u_if.zeraT,
              u_if.registraR_micro, u_if.registraR_macro, u_if.sinal_macro,
              u_if.sinal_valida_macro, u_if.troca_jogador, u_if.we_board,
              u_if.we_board_state, u_if.contaT, u_if.pronto};
   endfunction

   task automatic check(input string tag, input logic [4:0] exp_st,
                        input logic [14:0] exp_o);
      logic [19:0] obs;
      logic [19:0] exp_v;
      obs   = {u_if.db_estado, outs()};
      exp_v = {exp_st, exp_o};
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s: observed estado=%h outs=%b expected estado=%h outs=%b",
                tag, obs[19:15], obs[14:0], exp_v[19:15], exp_v[14:0]);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_jogada();
      u_if.tem_jogada = 1'b1;
      tick();
      u_if.tem_jogada = 1'b0;
   endtask

   initial begin
      vectors              = 0;
      miscompares          = 0;
      reset                = 1'b0;
      u_if.iniciar         = 1'b0;
      u_if.tem_jogada      = 1'b0;
      u_if.macro_vencida   = 1'b0;
      u_if.micro_jogada    = 1'b0;
      u_if.fim_jogo        = 1'b0;
      u_if.fimT            = 1'b0;

      #12;
      check("reset", 5'h00, O_00);
      reset = 1'b1;
      tick();
      check("idle_no_iniciar", 5'h00, O_00);

      u_if.iniciar = 1'b1;
      tick();
      check("preparacao", 5'h01, O_01);
      u_if.iniciar = 1'b0;
      tick();
      check("espera_macro", 5'h02, O_02);
      tick();
      check("espera_macro_hold", 5'h02, O_02);

      // macro rejected
      pulse_jogada();
      check("registra_macro", 5'h03, O_03);
      tick();
      check("valida_macro", 5'h04, O_04);
      u_if.macro_vencida = 1'b1;
      tick();
      check("macro_rejeitada", 5'h02, O_02);
      u_if.macro_vencida = 1'b0;

      // macro accepted
      pulse_jogada();
      check("registra_macro2", 5'h03, O_03);
      tick();
      check("valida_macro2", 5'h04, O_04);
      tick();
      check("espera_micro", 5'h05, O_05);
      u_if.iniciar = 1'b1;
      tick();
      check("iniciar_ignorado", 5'h05, O_05);
      u_if.iniciar = 1'b0;

      // micro rejected
      pulse_jogada();
      check("registra_micro", 5'h06, O_06);
      tick();
      check("valida_micro", 5'h07, O_07);
      u_if.micro_jogada = 1'b1;
      tick();
      check("micro_rejeitada", 5'h05, O_05);
      u_if.micro_jogada = 1'b0;

      // accepted move, auto macro path
      pulse_jogada();
      check("registra_micro2", 5'h06, O_06);
      tick();
      check("valida_micro2", 5'h07, O_07);
      tick();
      check("escreve_board", 5'h08, O_08);
      u_if.tem_jogada = 1'b1;
      tick();
      check("espera_board", 5'h09, O_09);
      tick();
      check("espera_board_hold_pulse", 5'h09, O_09);
      u_if.tem_jogada = 1'b0;
      tick();
      check("espera_board_hold", 5'h09, O_09);
      u_if.fimT = 1'b1;
      u_if.tem_jogada = 1'b1;
      tick();
      check("escreve_state", 5'h0A, O_0A);
      u_if.fimT = 1'b0;
      tick();
      check("verifica_fim", 5'h0B, O_0B);
      tick();
      check("troca", 5'h0C, O_0C);
      tick();
      check("verifica_proxima", 5'h0D, O_0D);
      u_if.tem_jogada = 1'b0;
      tick();
      check("registra_auto", 5'h10, O_10);
      tick();
      check("limpa_micro", 5'h11, O_11);
      tick();
      check("espera_micro_auto", 5'h05, O_05);

      // accepted move, next macro decided -> free pick
      pulse_jogada();
      tick();
      tick();
      check("escreve_board2", 5'h08, O_08);
      tick();
      u_if.fimT = 1'b1;
      tick();
      check("escreve_state2", 5'h0A, O_0A);
      u_if.fimT = 1'b0;
      tick();
      tick();
      check("troca2", 5'h0C, O_0C);
      u_if.macro_vencida = 1'b1;
      tick();
      tick();
      check("proxima_livre", 5'h0E, O_0E);
      u_if.macro_vencida = 1'b0;
      tick();
      check("espera_macro_livre", 5'h02, O_02);

      // async reset during espera_board
      pulse_jogada();
      tick();
      tick();
      pulse_jogada();
      tick();
      tick();
      tick();
      check("espera_board3", 5'h09, O_09);
      #2;
      reset = 1'b0;
      #1;
      check("reset_async", 5'h00, O_00);
      tick();
      check("reset_hold", 5'h00, O_00);
      reset = 1'b1;
      u_if.iniciar = 1'b1;
      tick();
      check("preparacao2", 5'h01, O_01);
      u_if.iniciar = 1'b0;
      tick();
      check("espera_macro3", 5'h02, O_02);

      // winning move -> fim, no troca
      pulse_jogada();
      tick();
      tick();
      check("espera_micro4", 5'h05, O_05);
      pulse_jogada();
      tick();
      tick();
      tick();
      u_if.fimT = 1'b1;
      tick();
      u_if.fimT = 1'b0;
      check("escreve_state4", 5'h0A, O_0A);
      tick();
      check("verifica_fim4", 5'h0B, O_0B);
      u_if.fim_jogo = 1'b1;
      tick();
      check("fim", 5'h0F, O_0F);
      u_if.fim_jogo = 1'b0;
      pulse_jogada();
      check("fim_ignora_jogada", 5'h0F, O_0F);
      tick();
      check("fim_hold", 5'h0F, O_0F);
      u_if.iniciar = 1'b1;
      tick();
      check("reinicia", 5'h01, O_01);
      u_if.iniciar = 1'b0;
      tick();
      check("reinicia_espera", 5'h02, O_02);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
